// File: rtl/hazard3_instr_align_buf_pkg.sv
// Shared types and width helpers for the fetch-to-decode instruction aligner.
package hazard3_instr_align_buf_pkg;

    typedef struct packed {
        logic        err;
        logic [15:0] dat;
    } hw_t;

    // What a jump_now cycle does, given the hold and lock state
    typedef enum logic [1:0] {
        JA_NONE     = 2'd0,
        JA_REDIRECT = 2'd1,
        JA_CAPTURE  = 2'd2,
        JA_RETARGET = 2'd3
    } jump_act_e;

    function automatic int hw_per_fetch(input int fetch_w);
        return fetch_w / 16;
    endfunction

    function automatic int level_w(input int depth_hw);
        return $clog2(depth_hw + 1);
    endfunction

endpackage

// File: rtl/hazard3_hw_fifo.sv
// Halfword shift-down queue: up to N_PUSH halfwords appended and 0..2 removed from the head per cycle.
// Entries 0/1 and the level are registered; the caller must not push beyond DEPTH.
module hazard3_hw_fifo
    import hazard3_instr_align_buf_pkg::*;
#(
    parameter  int DEPTH  = 6,
    parameter  int N_PUSH = 2,
    localparam int LW     = level_w(DEPTH),
    localparam int CW     = $clog2(N_PUSH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic [CW-1:0]     push_cnt_i,
    input  hw_t [N_PUSH-1:0]  push_dat_i,
    input  logic [1:0]        pop_cnt_i,
    output hw_t               head0_o,
    output hw_t               head1_o,
    output logic [LW-1:0]     level_o
);

    hw_t [DEPTH-1:0] mem_q, mem_d;
    logic [LW-1:0]   level_q, level_d, base;

    always_comb begin
        mem_d = mem_q >> ($bits(hw_t) * pop_cnt_i);
        base  = level_q - LW'(pop_cnt_i);
        // New halfwords land directly after whatever survives this cycle's pop
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < N_PUSH; j++) begin
                if (CW'(j) < push_cnt_i && LW'(i) == base + LW'(j)) begin
                    mem_d[i] = push_dat_i[j];
                end
            end
        end
        level_d = flush_i ? '0 : base + LW'(push_cnt_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '0;
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            level_q <= level_d;
        end
    end

    assign head0_o = mem_q[0];
    assign head1_o = mem_q[1];
    assign level_o = level_q;

endmodule

// File: rtl/hazard3_instr_align_buf.sv
// Fetch-to-decode aligner: buffers halfwords, presents the next 16/32-bit instruction with its PC,
// flushes on jumps and can hold a locked jump instruction across the flush.
module hazard3_instr_align_buf
    import hazard3_instr_align_buf_pkg::*;
#(
    parameter int                W_ADDR       = 32,
    parameter int                FETCH_W      = 32,
    parameter int                DEPTH_HW     = 6,
    parameter logic [W_ADDR-1:0] RESET_VECTOR = '0,
    parameter int                EXTENSION_C  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [FETCH_W-1:0]            f_data,
    input  logic                          f_data_vld,
    input  logic                          f_data_err,
    output logic                          f_data_rdy,
    input  logic                          jump_now,
    input  logic [W_ADDR-1:0]             jump_target,
    output logic [31:0]                   d_instr,
    output logic                          d_instr_vld,
    output logic                          d_instr_is_32b,
    output logic                          d_instr_err,
    output logic [W_ADDR-1:0]             d_pc,
    input  logic                          d_use,
    input  logic                          d_lock,
    output logic [$clog2(DEPTH_HW+1)-1:0] buf_level
);

    localparam int HPF = hw_per_fetch(FETCH_W);
    localparam int LW  = level_w(DEPTH_HW);
    localparam int DCW = $clog2(HPF);
    localparam int CW  = $clog2(HPF + 1);
    localparam logic [W_ADDR-1:0] PC_MASK = ~W_ADDR'(EXTENSION_C == 0 ? 3 : 1);
    localparam logic [W_ADDR-1:0] RV_AL   = RESET_VECTOR & PC_MASK;

    hw_t [HPF-1:0]     fetch_hw, push_dat;
    logic [CW-1:0]     push_cnt;
    logic [1:0]        pop_cnt;
    logic              push_fire;
    hw_t               head0, head1;
    logic [LW-1:0]     level;
    logic [W_ADDR-1:0] tgt;
    jump_act_e         act;
    logic              buf_is32, buf_vld, buf_err;
    logic [31:0]       buf_instr;

    logic [W_ADDR-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d;
    logic [DCW-1:0]    discard_q, discard_d;
    logic              hold_q, hold_d, hold_err_q, hold_err_d;
    logic [31:0]       hold_instr_q, hold_instr_d;

    assign f_data_rdy = level <= LW'(DEPTH_HW - HPF);
    assign buf_level  = level;

    // Leading halfwords below the target address are skipped on the first word after a redirect
    always_comb begin
        fetch_hw = '0;
        for (int j = 0; j < HPF; j++) begin
            fetch_hw[j].err = f_data_err;
            fetch_hw[j].dat = f_data[16*j +: 16];
        end
        push_dat  = fetch_hw >> ($bits(hw_t) * discard_q);
        push_fire = f_data_vld && f_data_rdy && !jump_now;
        push_cnt  = push_fire ? CW'(HPF) - CW'(discard_q) : '0;
    end

    always_comb begin
        buf_is32  = (EXTENSION_C == 0) || (head0.dat[1:0] == 2'b11);
        buf_vld   = (level >= LW'(2)) || (level != '0 && !buf_is32);
        buf_instr = buf_is32 ? {head1.dat, head0.dat} : {16'h0, head0.dat};
        buf_err   = (level != '0 && head0.err) || (buf_is32 && level >= LW'(2) && head1.err);
    end

    assign d_instr        = hold_q ? hold_instr_q : buf_instr;
    assign d_instr_vld    = hold_q || buf_vld;
    assign d_instr_is_32b = hold_q ? ((EXTENSION_C == 0) || hold_instr_q[1:0] == 2'b11) : buf_is32;
    assign d_instr_err    = hold_q ? hold_err_q : buf_err;
    assign d_pc           = pc_q;

    always_comb begin
        tgt = jump_target & PC_MASK;
        act = JA_NONE;
        if (jump_now) begin
            if (hold_q)
                act = d_lock ? JA_RETARGET : JA_REDIRECT;
            else
                act = (d_lock && buf_vld) ? JA_CAPTURE : JA_REDIRECT;
        end
        pop_cnt = 2'd0;
        if (!jump_now && !hold_q && d_use && buf_vld)
            pop_cnt = buf_is32 ? 2'd2 : 2'd1;

        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        discard_d    = push_fire ? '0 : discard_q;
        hold_d       = hold_q;
        hold_instr_d = hold_instr_q;
        hold_err_d   = hold_err_q;
        case (act)
            JA_REDIRECT: begin
                pc_d      = tgt;
                hold_d    = 1'b0;
                discard_d = tgt[DCW:1];
            end
            JA_CAPTURE: begin
                hold_d       = 1'b1;
                hold_instr_d = buf_instr;
                hold_err_d   = buf_err;
                pend_pc_d    = tgt;
                discard_d    = tgt[DCW:1];
            end
            JA_RETARGET: begin
                pend_pc_d = tgt;
                discard_d = tgt[DCW:1];
            end
            default: begin
                if (hold_q && !d_lock) begin
                    hold_d = 1'b0;
                    pc_d   = pend_pc_q;
                end else begin
                    pc_d = pc_q + W_ADDR'({pop_cnt, 1'b0});
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RV_AL;
            pend_pc_q    <= RV_AL;
            discard_q    <= RV_AL[DCW:1];
            hold_q       <= 1'b0;
            hold_instr_q <= '0;
            hold_err_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            discard_q    <= discard_d;
            hold_q       <= hold_d;
            hold_instr_q <= hold_instr_d;
            hold_err_q   <= hold_err_d;
        end
    end

    hazard3_hw_fifo #(
        .DEPTH  (DEPTH_HW),
        .N_PUSH (HPF)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (jump_now),
        .push_cnt_i (push_cnt),
        .push_dat_i (push_dat),
        .pop_cnt_i  (pop_cnt),
        .head0_o    (head0),
        .head1_o    (head1),
        .level_o    (level)
    );

endmodule

// File: tb/tb_hazard3_instr_align_buf.sv
// Bench for hazard3_instr_align_buf: directed vector table, hold/reset sequences, then random traffic vs a queue model.
module tb_hazard3_instr_align_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] f_data;
    logic        f_data_vld, f_data_err, f_data_rdy;
    logic        jump_now;
    logic [31:0] jump_target;
    logic [31:0] d_instr;
    logic        d_instr_vld, d_instr_is_32b, d_instr_err;
    logic [31:0] d_pc;
    logic        d_use, d_lock;
    logic [2:0]  buf_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard3_instr_align_buf #(
        .W_ADDR(32), .FETCH_W(32), .DEPTH_HW(6), .RESET_VECTOR(32'h0), .EXTENSION_C(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .f_data(f_data), .f_data_vld(f_data_vld), .f_data_err(f_data_err), .f_data_rdy(f_data_rdy),
        .jump_now(jump_now), .jump_target(jump_target),
        .d_instr(d_instr), .d_instr_vld(d_instr_vld), .d_instr_is_32b(d_instr_is_32b),
        .d_instr_err(d_instr_err), .d_pc(d_pc),
        .d_use(d_use), .d_lock(d_lock), .buf_level(buf_level)
    );

    typedef struct {
        logic fv; logic [31:0] fd; logic fe; logic jmp; logic [31:0] tgt; logic du; logic dl;
        logic ev; logic [31:0] ei; logic e32; logic ee; logic [31:0] epc; int el; logic er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic fv, logic [31:0] fd, logic fe, logic jmp, logic [31:0] tgt,
                                logic du, logic dl, logic ev, logic [31:0] ei, logic e32, logic ee,
                                logic [31:0] epc, int el, logic er);
        vec_t v;
        v = '{fv, fd, fe, jmp, tgt, du, dl, ev, ei, e32, ee, epc, el, er};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] fd, input logic fe, input logic jmp,
                         input logic [31:0] tgt, input logic du, input logic dl);
        f_data_vld = fv; f_data = fd; f_data_err = fe;
        jump_now = jmp; jump_target = tgt; d_use = du; d_lock = dl;
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic [31:0] ei, input logic e32,
                                 input logic ee, input logic [31:0] epc, input int el, input logic er);
        chk({tag, ".level"}, 32'(buf_level), el);
        chk({tag, ".rdy"}, 32'(f_data_rdy), 32'(er));
        chk({tag, ".vld"}, 32'(d_instr_vld), 32'(ev));
        chk({tag, ".pc"}, d_pc, epc);
        if (ev) begin
            chk({tag, ".is32"}, 32'(d_instr_is_32b), 32'(e32));
            chk({tag, ".instr"}, e32 ? d_instr : {16'h0, d_instr[15:0]}, ei);
            chk({tag, ".err"}, 32'(d_instr_err), 32'(ee));
        end
    endtask

    // Reference model: buffered halfwords as a queue of {err, data}
    logic [16:0] mq[$];
    logic [31:0] mpc, mpend, mhi;
    logic        mhold, mhe;
    int          mdisc;

    task automatic m_reset();
        mq.delete(); mpc = 32'h0; mpend = 32'h0; mhold = 1'b0; mhi = '0; mhe = 1'b0; mdisc = 0;
    endtask

    task automatic m_expect(output logic ev, output logic [31:0] ei, output logic e32, output logic ee);
        int          n;
        logic [16:0] h0, h1;
        n  = mq.size();
        h0 = (n > 0) ? mq[0] : '0;
        h1 = (n > 1) ? mq[1] : '0;
        if (mhold) begin
            ev = 1'b1; ei = mhi; e32 = (mhi[1:0] == 2'b11); ee = mhe;
        end else begin
            e32 = (n > 0) && (h0[1:0] == 2'b11);
            ev  = (n >= 2) || (n == 1 && !e32);
            ei  = e32 ? {h1[15:0], h0[15:0]} : {16'h0, h0[15:0]};
            ee  = h0[16] || (e32 && h1[16]);
        end
    endtask

    task automatic m_step(input logic fv, input logic [31:0] fd, input logic fe, input logic jmp,
                          input logic [31:0] tgt, input logic du, input logic dl);
        logic        v, i32, e;
        logic [31:0] ins, t;
        m_expect(v, ins, i32, e);
        t = tgt & ~32'h1;
        if (jmp) begin
            if (mhold) begin
                if (dl) mpend = t;
                else begin mhold = 1'b0; mpc = t; end
            end else if (dl && v) begin
                mhold = 1'b1; mhi = ins; mhe = e; mpend = t;
            end else begin
                mpc = t;
            end
            mq.delete();
            mdisc = int'(t[1]);
        end else begin
            if (mhold) begin
                if (!dl) begin mhold = 1'b0; mpc = mpend; end
            end else if (du && v) begin
                void'(mq.pop_front());
                if (i32) void'(mq.pop_front());
                mpc = mpc + (i32 ? 32'd4 : 32'd2);
            end
            if (fv) begin
                for (int j = mdisc; j < 2; j++) mq.push_back({fe, fd[16*j +: 16]});
                mdisc = 0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("reset.err", 32'(d_instr_err), 32'h0);
        check_outputs("reset", 0, 0, 0, 0, 32'h0, 0, 1);
        @(posedge clk); #1;

        //        fv fd            fe jmp tgt         du dl   ev ei            32 ee pc         lvl rdy
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,   0, 0,  0, 32'h0,        0, 0, 32'h000,  0, 1));
        tbl.push_back(mk(1, 32'h00130013, 0, 0, 32'h0,   0, 0,  0, 32'h0,        0, 0, 32'h000,  0, 1));
        tbl.push_back(mk(1, 32'h00000013, 0, 0, 32'h0,   1, 0,  1, 32'h00130013, 1, 0, 32'h000,  2, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,   1, 0,  1, 32'h00000013, 1, 0, 32'h004,  2, 1));
        tbl.push_back(mk(0, 32'h0,        0, 1, 32'h102, 0, 0,  0, 32'h0,        0, 0, 32'h008,  0, 1));
        tbl.push_back(mk(1, 32'h45010001, 0, 0, 32'h0,   0, 0,  0, 32'h0,        0, 0, 32'h102,  0, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,   1, 0,  1, 32'h00004501, 0, 0, 32'h102,  1, 1));
        tbl.push_back(mk(0, 32'h0,        0, 1, 32'h102, 0, 0,  0, 32'h0,        0, 0, 32'h104,  0, 1));
        tbl.push_back(mk(1, 32'h00134501, 0, 0, 32'h0,   0, 0,  0, 32'h0,        0, 0, 32'h102,  0, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,   0, 0,  0, 32'h0,        0, 0, 32'h102,  1, 1));
        tbl.push_back(mk(1, 32'h11110000, 0, 0, 32'h0,   0, 0,  0, 32'h0,        0, 0, 32'h102,  1, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,   0, 0,  1, 32'h00000013, 1, 0, 32'h102,  3, 1));
        tbl.push_back(mk(1, 32'h00000013, 0, 0, 32'h0,   0, 0,  1, 32'h00000013, 1, 0, 32'h102,  3, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,   0, 0,  1, 32'h00000013, 1, 0, 32'h102,  5, 0));
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,   1, 0,  1, 32'h00000013, 1, 0, 32'h102,  5, 0));
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,   1, 0,  1, 32'h00001111, 0, 0, 32'h106,  3, 1));
        tbl.push_back(mk(1, 32'h00000013, 0, 0, 32'h0,   0, 0,  1, 32'h00000013, 1, 0, 32'h108,  2, 1));
        tbl.push_back(mk(1, 32'h0080006F, 0, 0, 32'h0,   1, 0,  1, 32'h00000013, 1, 0, 32'h108,  4, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,   1, 0,  1, 32'h00000013, 1, 0, 32'h10C,  4, 1));
        tbl.push_back(mk(0, 32'h0,        0, 1, 32'h200, 0, 1,  1, 32'h0080006F, 1, 0, 32'h110,  2, 1));
        tbl.push_back(mk(1, 32'h00000013, 0, 0, 32'h0,   0, 1,  1, 32'h0080006F, 1, 0, 32'h110,  0, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,   1, 1,  1, 32'h0080006F, 1, 0, 32'h110,  2, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,   0, 0,  1, 32'h0080006F, 1, 0, 32'h110,  2, 1));
        tbl.push_back(mk(0, 32'h0,        0, 1, 32'h40,  0, 0,  1, 32'h00000013, 1, 0, 32'h200,  2, 1));
        tbl.push_back(mk(1, 32'h45014501, 1, 0, 32'h0,   0, 0,  0, 32'h0,        0, 0, 32'h040,  0, 1));
        tbl.push_back(mk(1, 32'h00000013, 0, 0, 32'h0,   1, 0,  1, 32'h00004501, 0, 1, 32'h040,  2, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,   1, 0,  1, 32'h00004501, 0, 1, 32'h042,  3, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,   1, 0,  1, 32'h00000013, 1, 0, 32'h044,  2, 1));
        tbl.push_back(mk(0, 32'h0,        0, 1, 32'h301, 0, 1,  0, 32'h0,        0, 0, 32'h048,  0, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,   0, 0,  0, 32'h0,        0, 0, 32'h300,  0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].fv, tbl[i].fd, tbl[i].fe, tbl[i].jmp, tbl[i].tgt, tbl[i].du, tbl[i].dl);
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].e32, tbl[i].ee,
                          tbl[i].epc, tbl[i].el, tbl[i].er);
            @(posedge clk); #1;
        end

        // Asynchronous reset between clock edges with data buffered
        drive(1, 32'h00130013, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.err", 32'(d_instr_err), 32'h0);
        check_outputs("arst", 0, 0, 0, 0, 32'h0, 0, 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Capture, retarget while held, then a same-cycle jump overriding the release
        drive(1, 32'h0080006F, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 1, 32'h500, 0, 1);
        @(negedge clk);
        check_outputs("cap", 1, 32'h0080006F, 1, 0, 32'h0, 2, 1);
        @(posedge clk); #1;
        drive(1, 32'h11111111, 0, 1, 32'h520, 0, 1);
        @(negedge clk);
        check_outputs("retgt", 1, 32'h0080006F, 1, 0, 32'h0, 0, 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 1, 32'h600, 0, 0);
        @(negedge clk);
        check_outputs("relj", 1, 32'h0080006F, 1, 0, 32'h0, 0, 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_outputs("relj2", 0, 0, 0, 0, 32'h600, 0, 1);
        @(posedge clk); #1;

        // Randomised traffic against the queue model
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        ev, e32, ee, fv, fe, jmp, du, dl;
            logic [31:0] ei, fd, tgt;
            logic [15:0] h;
            m_expect(ev, ei, e32, ee);
            fv = (mq.size() <= 4) && ($urandom_range(0, 3) != 0);
            fd = 32'h0;
            for (int j = 0; j < 2; j++) begin
                h = 16'($urandom);
                if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
                fd[16*j +: 16] = h;
            end
            fe  = ($urandom_range(0, 7) == 0);
            jmp = ($urandom_range(0, 15) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_0FFF);
            du  = ev && ($urandom_range(0, 1) == 1);
            dl  = ($urandom_range(0, 2) == 0);
            drive(fv, fd, fe, jmp, tgt, du, dl);
            @(negedge clk);
            check_outputs("rnd", ev, ei, e32, ee, mpc, mq.size(), mq.size() <= 4);
            @(posedge clk);
            m_step(fv, fd, fe, jmp, tgt, du, dl);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
